// File: rtl/icache_resp.sv
// icache_resp: instruction-side responder for the fetch stage.
// Direct-mapped, 2^INDEX_W lines of four 32-bit words, refilled by a burst
// read. Kseg1 fetches (va[31:29] == 3'b101) bypass the array as single words.
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_en_i, next_pc_i fetch address offered by the fetch stage
//   inst_o                instruction for the last accepted address
//   icache_ask_o          address registered this cycle
//   icache_stall_o        lookup/refill pending, inst_o not valid
//   mem_rd_*              burst read port to the memory bridge
module icache_resp #(
  parameter int unsigned INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] inst_o,
  output logic        icache_ask_o,
  output logic        icache_stall_o,
  output logic        mem_rd_req_o,
  output logic [31:0] mem_rd_addr_o,
  output logic [1:0]  mem_rd_len_o,
  input  logic        mem_rd_addr_ok_i,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_rd_data_ok_i,
  input  logic        mem_rd_last_i
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 32 - 4 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_REFILL,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:2]      pc_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];
  logic [1:0]       beat_q;
  logic [31:0]      resp_q;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               uncached;
  logic               hit;
  logic [31:0]        hit_word;
  logic               beat_fire;
  logic               unused_pc_lsbs;

  // Byte offset of the fetch address carries no information.
  assign unused_pc_lsbs = ^next_pc_i[1:0];

  // Physical address is {3'b000, va[28:0]}; fields are taken straight from pc_q.
  assign offset    = pc_q[3:2];
  assign index     = pc_q[4 +: INDEX_W];
  assign tag       = {3'b000, pc_q[28:4+INDEX_W]};
  assign uncached  = (pc_q[31:29] == 3'b101);
  assign hit_word  = data_q[index][offset];
  assign hit       = (state_q == S_LOOKUP) && !uncached && valid_q[index] &&
                     (tag_q[index] == tag);
  assign beat_fire = (state_q == S_REFILL) && mem_rd_data_ok_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = fetch_en_i ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        if (hit) begin
          state_d = fetch_en_i ? S_LOOKUP : S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ:    state_d = mem_rd_addr_ok_i ? S_REFILL : S_REQ;
      S_REFILL: state_d = (mem_rd_data_ok_i && mem_rd_last_i) ? S_RESP : S_REFILL;
      S_RESP:   state_d = fetch_en_i ? S_LOOKUP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    icache_ask_o   = 1'b0;
    icache_stall_o = 1'b0;
    mem_rd_req_o   = 1'b0;
    mem_rd_addr_o  = '0;
    mem_rd_len_o   = '0;
    inst_o         = resp_q;
    unique case (state_q)
      S_IDLE:   icache_ask_o = fetch_en_i;
      S_LOOKUP: begin
        if (hit) begin
          icache_ask_o = fetch_en_i;
          inst_o       = hit_word;
        end else begin
          icache_stall_o = 1'b1;
        end
      end
      S_REQ: begin
        icache_stall_o = 1'b1;
        mem_rd_req_o   = 1'b1;
        if (uncached) begin
          mem_rd_addr_o = {3'b000, pc_q[28:2], 2'b00};
          mem_rd_len_o  = 2'd0;
        end else begin
          mem_rd_addr_o = {3'b000, pc_q[28:4], 4'b0000};
          mem_rd_len_o  = 2'd3;
        end
      end
      S_REFILL: icache_stall_o = 1'b1;
      S_RESP:   icache_ask_o = fetch_en_i;
      default:  icache_stall_o = 1'b0;
    endcase
  end

  // Control datapath. resp_q doubles as the holding register so inst_o keeps
  // the last delivered instruction after a hit once the FSM drops to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      valid_q <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
    end else begin
      if (icache_ask_o) begin
        pc_q <= next_pc_i[31:2];
      end
      if (hit) begin
        resp_q <= hit_word;
      end
      if (beat_fire) begin
        if (beat_q == (uncached ? 2'b00 : offset)) begin
          resp_q <= mem_rd_data_i;
        end
        beat_q <= mem_rd_last_i ? 2'b00 : beat_q + 2'd1;
        if (mem_rd_last_i && !uncached) begin
          valid_q[index] <= 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (beat_fire && !uncached) begin
      data_q[index][beat_q] <= mem_rd_data_i;
      if (mem_rd_last_i) begin
        tag_q[index] <= tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_resp.sv
// Cycle-table bench for icache_resp: each row drives one cycle of inputs and
// lists the outputs expected in that same cycle.
module tb_icache_resp;

  logic        clk;
  logic        rst_n;
  logic        fetch_en_i;
  logic [31:0] next_pc_i;
  logic [31:0] inst_o;
  logic        icache_ask_o;
  logic        icache_stall_o;
  logic        mem_rd_req_o;
  logic [31:0] mem_rd_addr_o;
  logic [1:0]  mem_rd_len_o;
  logic        mem_rd_addr_ok_i;
  logic [31:0] mem_rd_data_i;
  logic        mem_rd_data_ok_i;
  logic        mem_rd_last_i;

  int tests_run = 0;
  int tests_failed = 0;

  icache_resp #(.INDEX_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_en_i       (fetch_en_i),
    .next_pc_i        (next_pc_i),
    .inst_o           (inst_o),
    .icache_ask_o     (icache_ask_o),
    .icache_stall_o   (icache_stall_o),
    .mem_rd_req_o     (mem_rd_req_o),
    .mem_rd_addr_o    (mem_rd_addr_o),
    .mem_rd_len_o     (mem_rd_len_o),
    .mem_rd_addr_ok_i (mem_rd_addr_ok_i),
    .mem_rd_data_i    (mem_rd_data_i),
    .mem_rd_data_ok_i (mem_rd_data_ok_i),
    .mem_rd_last_i    (mem_rd_last_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic        aok;
    logic        dok;
    logic        last;
    logic [31:0] data;
    logic        e_ask;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_len;
    logic        chk_inst;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [31:0] pc,
                              input logic aok, input logic dok, input logic last,
                              input logic [31:0] data,
                              input logic e_ask, input logic e_stall,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [1:0] e_len,
                              input logic chk_inst, input logic [31:0] e_inst);
    vec_t v;
    v.en = en; v.pc = pc; v.aok = aok; v.dok = dok; v.last = last; v.data = data;
    v.e_ask = e_ask; v.e_stall = e_stall; v.e_req = e_req; v.e_addr = e_addr;
    v.e_len = e_len; v.chk_inst = chk_inst; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic aok,
                       input logic dok, input logic last, input logic [31:0] data);
    fetch_en_i       = en;
    next_pc_i        = pc;
    mem_rd_addr_ok_i = aok;
    mem_rd_data_ok_i = dok;
    mem_rd_last_i    = last;
    mem_rd_data_i    = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " inst"},  inst_o, 32'h0);
    chk({tag, " ask"},   {31'b0, icache_ask_o}, 32'h0);
    chk({tag, " stall"}, {31'b0, icache_stall_o}, 32'h0);
    chk({tag, " req"},   {31'b0, mem_rd_req_o}, 32'h0);
    chk({tag, " addr"},  mem_rd_addr_o, 32'h0);
    chk({tag, " len"},   {30'b0, mem_rd_len_o}, 32'h0);
  endtask

  // Inputs applied just after a rising edge, outputs sampled on the falling edge.
  task automatic run_row(input string tag, input vec_t v);
    drive(v.en, v.pc, v.aok, v.dok, v.last, v.data);
    @(negedge clk);
    chk({tag, " ask"},   {31'b0, icache_ask_o},   {31'b0, v.e_ask});
    chk({tag, " stall"}, {31'b0, icache_stall_o}, {31'b0, v.e_stall});
    chk({tag, " req"},   {31'b0, mem_rd_req_o},   {31'b0, v.e_req});
    chk({tag, " addr"},  mem_rd_addr_o, v.e_addr);
    chk({tag, " len"},   {30'b0, mem_rd_len_o},   {30'b0, v.e_len});
    if (v.chk_inst) chk({tag, " inst"}, inst_o, v.e_inst);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Uncached boot fetch twice, cached miss, streaming hits, index conflict.
    //           en  pc            aok  dok  last data            ask stall req addr          len ci inst
    tbl.push_back(mk(1, 32'hBFC0_0000, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 1, 1, 32'h1FC0_0000, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 1, 32'h3C08_0001,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(1, 32'hBFC0_0000, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'h3C08_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 1, 1, 32'h1FC0_0000, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 1, 32'h3C08_0002,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         0, 1, 32'h3C08_0002));
    tbl.push_back(mk(1, 32'h8000_0104, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'h3C08_0002));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 1, 1, 32'h0000_0100, 3, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hA0A0_0000,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hA0A0_0001,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hA0A0_0002,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 1, 32'hA0A0_0003,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h8000_0108, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0001));
    tbl.push_back(mk(1, 32'h8000_0100, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0002));
    tbl.push_back(mk(1, 32'h8000_0104, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0000));
    tbl.push_back(mk(1, 32'h8000_0108, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0001));
    tbl.push_back(mk(1, 32'h8000_010C, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0002));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         0, 1, 32'hA0A0_0003));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         0, 1, 32'hA0A0_0003));
    tbl.push_back(mk(1, 32'h8000_0500, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hA0A0_0003));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 1, 1, 32'h0000_0500, 3, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hB0B0_0000,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hB0B0_0001,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hB0B0_0002,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 1, 32'hB0B0_0003,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h8000_0100, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,         0, 1, 32'hB0B0_0000));
    tbl.push_back(mk(1, 32'h8000_0700, 0, 0, 0, 32'h0,          0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         1, 1, 0, 32'hDEAD_BEEF,  0, 1, 1, 32'h0000_0100, 3, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hC0C0_0000,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hC0C0_0001,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'hC0C0_0002,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 1, 32'hC0C0_0003,  0, 1, 0, 32'h0,         0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         0, 1, 32'hC0C0_0000));
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         0, 1, 32'hC0C0_0000));

    for (int i = 0; i < tbl.size(); i++) begin
      run_row($sformatf("row%0d", i), tbl[i]);
    end

    // addr_ok withheld five cycles while fetch_en_i toggles.
    run_row("hold_ask", mk(1, 32'h8000_020C, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 32'h0));
    run_row("hold_lkp", mk(1, 32'h8000_0600, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0));
    for (int i = 0; i < 5; i++) begin
      run_row($sformatf("hold_wait%0d", i),
              mk(((i % 2) == 0), 32'h8000_0000 + 32'(i * 16), 0, 0, 0, 32'h0,
                 0, 1, 1, 32'h0000_0200, 3, 0, 32'h0));
    end
    run_row("hold_acc", mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 1, 1, 32'h0000_0200, 3, 0, 32'h0));
    for (int i = 0; i < 4; i++) begin
      run_row($sformatf("hold_beat%0d", i),
              mk(0, 32'h0, 0, 1, (i == 3), 32'hD0D0_0000 + 32'(i),
                 0, 1, 0, 32'h0, 0, 0, 32'h0));
    end
    run_row("hold_resp", mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'hD0D0_0003));

    // Reset asserted during beat 2 of a refill.
    run_row("rst_ask", mk(1, 32'h8000_0300, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 1, 32'hD0D0_0003));
    run_row("rst_lkp", mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0));
    run_row("rst_req", mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 1, 1, 32'h0000_0300, 3, 0, 32'h0));
    run_row("rst_b0",  mk(0, 32'h0, 0, 1, 0, 32'hE0E0_0000, 0, 1, 0, 32'h0, 0, 0, 32'h0));
    run_row("rst_b1",  mk(0, 32'h0, 0, 1, 0, 32'hE0E0_0001, 0, 1, 0, 32'h0, 0, 0, 32'h0));
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hE0E0_0002);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_row("post_ask", mk(1, 32'h8000_0300, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 1, 32'h0));
    run_row("post_lkp", mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0));
    run_row("post_req", mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h0000_0300, 3, 0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
